rtttl_playback_arbiter: RTL and testbench

Shares the single RTTTL sequencer and its tone-generator output among up to NUM_REQ song requesters (buttons, host register writes, alarm triggers). Requests are latched and granted round-robin. The block then:

- launches the sequencer with a song select,
- gates the sequencer's octave/note stream through to the tone generator only while a granted song plays,
- enforces a muted gap between consecutive songs.

It sits between the request sources and the `rtttl_sequencer`/tone-generator pair.

---
 rtl/rtttl_playback_arbiter.sv | 153 +++++++++++++++
 tb/tb_rtttl_playback_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtttl_playback_arbiter.sv
// Round-robin arbiter sharing one RTTTL sequencer and tone output among NUM_REQ song requesters.
// Latency: req->pending 1 cycle, pending->seq_start 1 cycle; no backpressure, requests latch until served.
module rtttl_playback_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int TICK_MAX      = 23810,
    parameter int GAP_TICKS     = 16,
    parameter int START_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       cancel,
    input  logic                       seq_busy,
    input  logic [3:0]                 seq_octave,
    input  logic [3:0]                 seq_note,
    output logic                       seq_start,
    output logic [$clog2(NUM_REQ)-1:0] seq_sel,
    output logic                       seq_abort,
    output logic [3:0]                 octave,
    output logic [3:0]                 note,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         pending,
    output logic                       idle,
    output logic                       timeout_err
);

    localparam int SW = $clog2(NUM_REQ);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] PLAY      = 3'd3;
    localparam logic [2:0] ABORT     = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;

    logic [2:0]         state;
    logic [SW-1:0]      ptr;
    logic [7:0]         tmo_cnt;
    logic [14:0]        tick_cnt;
    logic [7:0]         gap_cnt;

    logic               win_vld;
    logic [SW-1:0]      win_idx;
    logic [SW-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0] win_onehot;

    // Scan upward from ptr, wrapping at NUM_REQ; first pending index wins.
    always_comb begin
        int      scan;
        logic [SW-1:0] scan_idx;
        scan       = 0;
        scan_idx   = '0;
        win_vld    = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan     = (int'(ptr) + i) % NUM_REQ;
            scan_idx = SW'(scan);
            if (!win_vld && pending[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
        if (win_vld) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    assign ptr_nxt   = (win_idx == SW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign seq_start = (state == LAUNCH);
    assign seq_abort = (state == ABORT);
    assign idle      = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            pending     <= '0;
            grant       <= '0;
            seq_sel     <= '0;
            octave      <= 4'd0;
            note        <= 4'd0;
            timeout_err <= 1'b0;
            tmo_cnt     <= 8'd0;
            tick_cnt    <= 15'd0;
            gap_cnt     <= 8'd0;
        end else begin
            // A req in the LAUNCH cycle re-sets the bit being cleared, so it re-queues.
            pending <= (pending & ~((state == LAUNCH) ? grant : '0)) | req;
            octave  <= (state == PLAY) ? seq_octave : 4'd0;
            note    <= (state == PLAY) ? seq_note   : 4'd0;

            if (state != GAP) begin
                tick_cnt <= 15'd0;
                gap_cnt  <= 8'd0;
            end

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant   <= win_onehot;
                        seq_sel <= win_idx;
                        ptr     <= ptr_nxt;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= 8'd0;
                    state   <= cancel ? ABORT : WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (cancel) begin
                        state <= ABORT;
                    end else if (seq_busy) begin
                        state <= PLAY;
                    end else if (tmo_cnt == 8'(START_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        state       <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                PLAY: begin
                    if (cancel) begin
                        state <= ABORT;
                    end else if (!seq_busy) begin
                        grant <= '0;
                        state <= GAP;
                    end
                end
                ABORT: begin
                    grant <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (tick_cnt == 15'(TICK_MAX)) begin
                        tick_cnt <= 15'd0;
                        if (gap_cnt == 8'(GAP_TICKS - 1)) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 15'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtttl_playback_arbiter.sv
// Bench for rtttl_playback_arbiter: directed scenarios plus randomized requests against a round-robin model.
module tb_rtttl_playback_arbiter;

    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       cancel;
    logic       seq_busy;
    logic [3:0] seq_octave;
    logic [3:0] seq_note;
    logic       seq_start;
    logic [1:0] seq_sel;
    logic       seq_abort;
    logic [3:0] octave;
    logic [3:0] note;
    logic [3:0] grant;
    logic [3:0] pending;
    logic       idle;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_from = 0;
    int busy_to   = 0;
    int busy_len  = 10;
    bit auto_en   = 1'b1;
    int model_ptr = 0;

    always #5 clk = ~clk;

    rtttl_playback_arbiter #(
        .NUM_REQ(NR), .TICK_MAX(3), .GAP_TICKS(2), .START_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .cancel(cancel), .seq_busy(seq_busy),
        .seq_octave(seq_octave), .seq_note(seq_note), .seq_start(seq_start),
        .seq_sel(seq_sel), .seq_abort(seq_abort), .octave(octave), .note(note),
        .grant(grant), .pending(pending), .idle(idle), .timeout_err(timeout_err)
    );

    // Round-robin rule: first set bit at or above p, wrapping.
    function automatic int pick(input logic [3:0] m, input int p);
        int j;
        for (int i = 0; i < NR; i++) begin
            j = (p + i) % NR;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    // Advance one cycle; also plays the sequencer: busy 2 cycles after start, busy_len cycles long.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        seq_busy = auto_en && (cyc >= busy_from) && (cyc < busy_to);
        if (seq_start === 1'b1 && auto_en) begin
            busy_from = cyc + 2;
            busy_to   = cyc + 2 + busy_len;
        end
        if (seq_abort === 1'b1) busy_to = cyc + 1;
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (idle === 1'b1 && pending === 4'b0) ok = 1'b1;
        end
    endtask

    task automatic wait_launch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 150 && !ok; i++) begin
            tick();
            if (seq_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0; cancel = 1'b0; seq_busy = 1'b0;
        seq_octave = 4'd5; seq_note = 4'd6;
        repeat (3) @(posedge clk);
        #1;
        total++; if (grant !== 4'b0 || pending !== 4'b0 || seq_sel !== 2'd0) begin bad++; $display("FAIL reset_regs: grant=%b pending=%b sel=%0d want 0", grant, pending, seq_sel); end
        total++; if (octave !== 4'd0 || note !== 4'd0) begin bad++; $display("FAIL reset_tone: octave=%0d note=%0d want 0", octave, note); end
        total++; if (seq_start !== 1'b0 || seq_abort !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL reset_pulses: start=%b abort=%b terr=%b want 0", seq_start, seq_abort, timeout_err); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: idle=%b want 1", idle); end
        rst = 1'b0;
        tick();
        total++; if (idle !== 1'b1 || seq_start !== 1'b0) begin bad++; $display("FAIL reset_release: idle=%b start=%b want 1/0", idle, seq_start); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] mp;
        int e;
        for (int phase = 0; phase < 2; phase++) begin
            wait_quiet(ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_quiet: idle=%b pending=%b want idle", idle, pending); end
            mp = (phase == 0) ? 4'b1011 : 4'b1001;
            req = mp;
            tick();
            req = 4'b0;
            for (int s = 0; s < ((phase == 0) ? 3 : 2); s++) begin
                wait_launch(ok);
                e = pick(mp, model_ptr);
                total++; if (!ok || seq_sel !== 2'(e) || grant !== 4'(1 << e)) begin bad++; $display("FAIL rr_order: phase=%0d slot=%0d start=%b sel=%0d grant=%b want sel=%0d", phase, s, seq_start, seq_sel, grant, e); end
                mp[e] = 1'b0;
                model_ptr = (e + 1) % NR;
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [7:0] exp_tone;
        wait_quiet(ok);
        total++; if (!ok) begin bad++; $display("FAIL single_quiet: idle=%b want 1", idle); end
        busy_len = 10;
        req = 4'b0001;
        tick();
        req = 4'b0;
        total++; if (pending !== 4'b0001 || seq_start !== 1'b0) begin bad++; $display("FAIL single_pend: pending=%b start=%b want 0001/0", pending, seq_start); end
        tick();
        total++; if (seq_start !== 1'b1 || seq_sel !== 2'd0 || grant !== 4'b0001) begin bad++; $display("FAIL single_launch: start=%b sel=%0d grant=%b want 1/0/0001", seq_start, seq_sel, grant); end
        model_ptr = 1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            exp_tone = (k >= 4 && k <= 13) ? 8'h56 : 8'h00;
            total++; if ({octave, note} !== exp_tone) begin bad++; $display("FAIL single_tone: k=%0d got %h want %h", k, {octave, note}, exp_tone); end
            total++; if (grant !== ((k <= 12) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL single_grant: k=%0d grant=%b", k, grant); end
            total++; if (idle !== (k >= 21)) begin bad++; $display("FAIL single_gap: k=%0d idle=%b want %b", k, idle, (k >= 21)); end
        end
    endtask

    task automatic test_cancel();
        bit ok;
        wait_quiet(ok);
        req = 4'b0100;
        tick();
        req = 4'b0;
        wait_launch(ok);
        total++; if (!ok || seq_sel !== 2'd2) begin bad++; $display("FAIL cancel_launch: start=%b sel=%0d want 1/2", seq_start, seq_sel); end
        model_ptr = 3;
        repeat (5) tick();
        total++; if ({octave, note} !== 8'h56) begin bad++; $display("FAIL cancel_playing: got %h want 56", {octave, note}); end
        cancel = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            cancel = (k == 4);
            if (k == 1) begin
                total++; if (seq_abort !== 1'b1 || seq_start !== 1'b0 || {octave, note} !== 8'h56) begin bad++; $display("FAIL cancel_abort: abort=%b start=%b tone=%h want 1/0/56", seq_abort, seq_start, {octave, note}); end
            end
            if (k == 2) begin
                total++; if (seq_abort !== 1'b0 || {octave, note} !== 8'h00 || grant !== 4'b0) begin bad++; $display("FAIL cancel_mute: abort=%b tone=%h grant=%b want 0/00/0", seq_abort, {octave, note}, grant); end
            end
            if (k == 5) begin
                total++; if (seq_abort !== 1'b0) begin bad++; $display("FAIL cancel_in_gap: abort=%b want 0", seq_abort); end
            end
            if (k == 9) begin
                total++; if (idle !== 1'b0) begin bad++; $display("FAIL cancel_gap_len: idle=%b want 0 at gap end", idle); end
            end
            if (k == 10) begin
                total++; if (idle !== 1'b1) begin bad++; $display("FAIL cancel_gap_end: idle=%b want 1", idle); end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [3:0] mp;
        int e1, e2;
        wait_quiet(ok);
        auto_en = 1'b0;
        mp = 4'b0011;
        req = mp;
        tick();
        req = 4'b0;
        wait_launch(ok);
        e1 = pick(mp, model_ptr);
        total++; if (!ok || seq_sel !== 2'(e1)) begin bad++; $display("FAIL tmo_launch: sel=%0d want %0d", seq_sel, e1); end
        mp[e1] = 1'b0;
        model_ptr = (e1 + 1) % NR;
        e2 = pick(mp, model_ptr);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k <= 4) begin
                total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early: k=%0d terr=%b want 0", k, timeout_err); end
            end
            if (k == 5) begin
                total++; if (timeout_err !== 1'b1 || grant !== 4'b0 || idle !== 1'b0) begin bad++; $display("FAIL tmo_flag: terr=%b grant=%b idle=%b want 1/0/0", timeout_err, grant, idle); end
            end
            if (k == 13) begin
                total++; if (idle !== 1'b1 || seq_start !== 1'b0) begin bad++; $display("FAIL tmo_gap: idle=%b start=%b want 1/0", idle, seq_start); end
            end
            if (k == 14) begin
                total++; if (seq_start !== 1'b1 || seq_sel !== 2'(e2)) begin bad++; $display("FAIL tmo_next: start=%b sel=%0d want 1/%0d", seq_start, seq_sel, e2); end
            end
        end
        model_ptr = (e2 + 1) % NR;
        wait_quiet(ok);
        total++; if (!ok || timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: terr=%b idle=%b want 1/1", timeout_err, idle); end
        auto_en = 1'b1;
    endtask

    task automatic test_requeue();
        bit ok;
        wait_quiet(ok);
        req = 4'b0010;
        tick();
        tick();
        total++; if (seq_start !== 1'b1 || seq_sel !== 2'd1) begin bad++; $display("FAIL rq_launch: start=%b sel=%0d want 1/1", seq_start, seq_sel); end
        model_ptr = 2;
        tick();
        req = 4'b0;
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL rq_kept: pending=%b want 0010", pending); end
        for (int k = 2; k <= 23; k++) begin
            tick();
            if (k == 21) begin
                total++; if (idle !== 1'b1 || seq_start !== 1'b0) begin bad++; $display("FAIL rq_idle: idle=%b start=%b want 1/0", idle, seq_start); end
            end
            if (k == 22) begin
                total++; if (seq_start !== 1'b1 || seq_sel !== 2'd1) begin bad++; $display("FAIL rq_again: start=%b sel=%0d want 1/1", seq_start, seq_sel); end
            end
            if (k == 23) begin
                total++; if (pending !== 4'b0) begin bad++; $display("FAIL rq_cleared: pending=%b want 0", pending); end
            end
        end
        model_ptr = 2;
    endtask

    task automatic test_async_reset();
        bit ok;
        int starts;
        wait_quiet(ok);
        req = 4'b1000;
        tick();
        req = 4'b0;
        wait_launch(ok);
        repeat (6) tick();
        total++; if (!ok || {octave, note} !== 8'h56) begin bad++; $display("FAIL ar_playing: tone=%h want 56", {octave, note}); end
        #3 rst = 1'b1;
        #1;
        total++; if (grant !== 4'b0 || pending !== 4'b0 || seq_sel !== 2'd0 || {octave, note} !== 8'h00) begin bad++; $display("FAIL ar_regs: grant=%b pending=%b sel=%0d tone=%h want 0", grant, pending, seq_sel, {octave, note}); end
        total++; if (seq_start !== 1'b0 || seq_abort !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL ar_ctrl: start=%b abort=%b idle=%b want 0/0/1", seq_start, seq_abort, idle); end
        seq_busy = 1'b0;
        busy_from = 0;
        busy_to = 0;
        model_ptr = 0;
        #7 rst = 1'b0;
        starts = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (seq_start !== 1'b0) starts++;
        end
        total++; if (starts !== 0 || idle !== 1'b1) begin bad++; $display("FAIL ar_quiet: starts=%0d idle=%b want 0/1", starts, idle); end
    endtask

    task automatic test_random();
        logic [3:0] mp, mp_old, req_prev, r;
        int e;
        mp = 4'b0;
        req_prev = 4'b0;
        for (int t = 0; t < 1200; t++) begin
            tick();
            mp_old = mp;
            mp = mp | req_prev;
            total++; if (pending !== mp) begin bad++; $display("FAIL rnd_pending: t=%0d pending=%b want %b", t, pending, mp); end
            if (seq_start === 1'b1) begin
                e = pick(mp_old, model_ptr);
                total++; if (e < 0 || seq_sel !== 2'(e) || grant !== 4'(1 << e)) begin bad++; $display("FAIL rnd_winner: t=%0d sel=%0d grant=%b want %0d", t, seq_sel, grant, e); end
                if (e >= 0) begin
                    mp[e] = 1'b0;
                    model_ptr = (e + 1) % NR;
                end
            end
            total++; if ((seq_start === 1'b1 && seq_abort === 1'b1) || !$onehot0(grant)) begin bad++; $display("FAIL rnd_invariant: t=%0d start=%b abort=%b grant=%b", t, seq_start, seq_abort, grant); end
            r = (t < 800 && $urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            req = r;
            req_prev = r;
            cancel = (t < 800) && ($urandom_range(0, 30) == 0);
            busy_len = $urandom_range(1, 8);
            seq_octave = 4'($urandom_range(0, 15));
            seq_note = 4'($urandom_range(0, 15));
        end
        total++; if (idle !== 1'b1 || mp !== 4'b0) begin bad++; $display("FAIL rnd_drain: idle=%b model_pending=%b want 1/0", idle, mp); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_cancel();
        test_timeout();
        test_requeue();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
